// File: rtl/uart_byte_receiver_pkg.sv
// Shared UART definitions: frame shape, receiver state encodings and the
// clock-to-baud divisor rounding used by both directions of the link.
package uart_byte_receiver_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Nearest-integer clocks per bit; callers must keep the result >= 4.
  function automatic int round_divisor(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_receiver_baud_counter.sv
// Reloadable down-counter pacing UART bit sampling; tick marks the cycle the
// count reaches zero. Shared with the transmitter.
module uart_baud_counter #(
  parameter int divisor = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(divisor);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(divisor - 1);
  // Half reload is two short: one cycle is spent detecting the start edge and
  // one entering START, so the start sample lands mid-bit.
  localparam logic [CW-1:0] HALF_RELOAD = CW'(divisor / 2 - 2);

  logic [CW-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = half ? HALF_RELOAD : FULL_RELOAD;
    end else if (count_reg != '0) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tick = (count_reg == '0);

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with a one-byte holding register on a valid/ready
// handshake; flags framing errors and dropped bytes with one-cycle pulses.
module uart_byte_receiver
  import uart_byte_receiver_pkg::*;
#(
  parameter int clock_freq = 60000000,
  parameter int baud_rate  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int divisor = round_divisor(clock_freq, baud_rate);

  logic [1:0] sync_reg;
  logic       rx_s;
  logic [2:0] state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] bit_reg, bit_next;
  logic       tick, load, half;
  logic       byte_done, stop_bad;
  logic [7:0] data_reg;
  logic       data_valid_reg, frame_error_reg, overrun_reg;

  // Synchronisers reset high so reset never looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end
  assign rx_s = sync_reg[1];

  uart_baud_counter #(.divisor(divisor)) u_baud (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .half  (half),
    .tick  (tick)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) state_next = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_next = rx_s ? ST_IDLE : ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = {rx_s, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'(DATA_BITS - 1)) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_s) begin
            byte_done  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reload on every state change, and between data bits.
  assign load = (state_next != state_reg) || ((state_reg == ST_DATA) && tick);
  assign half = (state_next == ST_START);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
    end
  end

  // A load on the same cycle as a transfer takes the slot the transfer frees.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_reg        <= '0;
      data_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      frame_error_reg <= stop_bad;
      overrun_reg     <= byte_done && data_valid_reg && !data_ready;
      if (byte_done && (!data_valid_reg || data_ready)) begin
        data_reg       <= shift_reg;
        data_valid_reg <= 1'b1;
      end else if (data_valid_reg && data_ready) begin
        data_valid_reg <= 1'b0;
      end
    end
  end

  assign data        = data_reg;
  assign data_valid  = data_valid_reg;
  assign frame_error = frame_error_reg;
  assign overrun     = overrun_reg;

endmodule
